// File: rtl/blur_nxn.sv
// KxK binomial blur over a raster pixel stream: K-1 line buffers feed a KxK
// window, then a 3-stage separable weighted sum produces one pixel per advance.
module blur_nxn #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int K      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [DATA_W-1:0]        input_pixel,
  input  logic [1:0]               mode,
  output logic                     in_ready,
  output logic                     rd_flag,
  output logic [DATA_W-1:0]        output_pixel,
  output logic [$clog2(IMG_H)-1:0] rows_written,
  output logic [$clog2(IMG_W)-1:0] cols_written,
  output logic                     frame_done
);

  localparam int R      = (K - 1) / 2;
  localparam int FILL_N = R * IMG_W + R;
  localparam int PIX_N  = IMG_W * IMG_H;
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int CNT_W  = $clog2(PIX_N + 1);
  localparam int FL_W   = $clog2(FILL_N + 1);
  localparam int HS_W   = DATA_W + K - 1;
  localparam int ACC_W  = DATA_W + 2 * (K - 1);
  localparam int SHIFT  = 2 * (K - 1);
  localparam logic [ACC_W-1:0] ROUND = ACC_W'(1) << (2 * K - 3);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  // Binomial coefficient C(K-1, i), built incrementally so every step is exact.
  function automatic int binom(input int i);
    int c;
    c = 1;
    for (int j = 0; j < i; j++) c = c * (K - 1 - j) / (j + 1);
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   inCount_q, inCount_d;
  logic [FL_W-1:0]    flushCount_q, flushCount_d;
  logic [ROW_W-1:0]   outRow_q, outRow_d;
  logic [COL_W-1:0]   outCol_q, outCol_d;
  logic [1:0]         frameMode_q, frameMode_d;
  logic [COL_W-1:0]   colPtr_q, colPtrNext;

  logic               accept, advance, produce;
  logic               border, last, gauss;
  logic [DATA_W-1:0]  newPix;

  logic [DATA_W-1:0]  lineBuf_q [K-1][IMG_W];
  logic [DATA_W-1:0]  win_q [K][K];
  logic [DATA_W-1:0]  colVec [K];

  logic [HS_W-1:0]    hSum [K];
  logic [ACC_W-1:0]   vSum;

  logic               v0_q, v1_q, v2_q;
  logic               bypass0_q, bypass1_q, bypass2_q;
  logic               last0_q, last1_q, last2_q;
  logic [ROW_W-1:0]   row0_q, row1_q, row2_q;
  logic [COL_W-1:0]   col0_q, col1_q, col2_q;
  logic [HS_W-1:0]    hs1_q [K];
  logic [ACC_W-1:0]   sum2_q;
  logic [DATA_W-1:0]  center1_q, center2_q;

  assign in_ready   = (state_q != FLUSH);
  assign accept     = en && in_ready;
  assign advance    = accept || (state_q == FLUSH);
  assign produce    = advance && (state_q != FILL);
  assign newPix     = (state_q == FLUSH) ? '0 : input_pixel;
  assign colPtrNext = (colPtr_q == COL_W'(IMG_W - 1)) ? '0 : colPtr_q + 1'b1;

  assign border = (int'(outRow_q) < R) || (int'(outRow_q) >= IMG_H - R) ||
                  (int'(outCol_q) < R) || (int'(outCol_q) >= IMG_W - R);
  assign last   = (outRow_q == ROW_W'(IMG_H - 1)) && (outCol_q == COL_W'(IMG_W - 1));
  assign gauss  = (frameMode_q == 2'b01);

  always_comb begin
    state_d      = state_q;
    inCount_d    = inCount_q;
    flushCount_d = flushCount_q;
    outRow_d     = outRow_q;
    outCol_d     = outCol_q;
    frameMode_d  = frameMode_q;

    if (accept && inCount_q == '0) frameMode_d = mode;
    if (accept) inCount_d = inCount_q + 1'b1;

    if (produce) begin
      if (outCol_q == COL_W'(IMG_W - 1)) begin
        outCol_d = '0;
        outRow_d = outRow_q + 1'b1;
      end else begin
        outCol_d = outCol_q + 1'b1;
      end
    end

    case (state_q)
      FILL: if (accept && inCount_q == CNT_W'(FILL_N - 1)) state_d = RUN;
      RUN:  if (accept && inCount_q == CNT_W'(PIX_N - 1)) state_d = FLUSH;
      FLUSH: begin
        flushCount_d = flushCount_q + 1'b1;
        if (flushCount_q == FL_W'(FILL_N - 1)) begin
          state_d      = FILL;
          inCount_d    = '0;
          flushCount_d = '0;
          outRow_d     = '0;
          outCol_d     = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // colVec[0] is the newest row; colVec[j] is the same column j rows earlier.
  always_comb begin
    colVec[0] = newPix;
    for (int j = 1; j < K; j++) colVec[j] = lineBuf_q[j-1][colPtr_q];
  end

  always_comb begin
    for (int j = 0; j < K; j++) begin
      hSum[j] = '0;
      for (int i = 0; i < K; i++)
        hSum[j] = hSum[j] + HS_W'(win_q[j][i]) * HS_W'(binom(i));
    end
    vSum = '0;
    for (int j = 0; j < K; j++)
      vSum = vSum + ACC_W'(hs1_q[j]) * ACC_W'(binom(j));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FILL;
      inCount_q    <= '0;
      flushCount_q <= '0;
      outRow_q     <= '0;
      outCol_q     <= '0;
      frameMode_q  <= '0;
      colPtr_q     <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      rd_flag      <= 1'b0;
      frame_done   <= 1'b0;
      output_pixel <= '0;
      rows_written <= '0;
      cols_written <= '0;
    end else begin
      state_q      <= state_d;
      inCount_q    <= inCount_d;
      flushCount_q <= flushCount_d;
      outRow_q     <= outRow_d;
      outCol_q     <= outCol_d;
      frameMode_q  <= frameMode_d;
      if (advance) colPtr_q <= colPtrNext;
      v0_q       <= produce;
      v1_q       <= v0_q;
      v2_q       <= v1_q;
      rd_flag    <= v2_q;
      frame_done <= v2_q && last2_q;
      if (v2_q) begin
        output_pixel <= bypass2_q ? center2_q : DATA_W'((sum2_q + ROUND) >> SHIFT);
        rows_written <= row2_q;
        cols_written <= col2_q;
      end
    end
  end

  // Storage and pipeline data carry no reset; only the valid bits above qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int j = 0; j < K - 1; j++) lineBuf_q[j][colPtr_q] <= colVec[j];
      for (int j = 0; j < K; j++) begin
        for (int i = 0; i < K - 1; i++) win_q[j][i] <= win_q[j][i+1];
        win_q[j][K-1] <= colVec[j];
      end
    end
    if (produce) begin
      row0_q    <= outRow_q;
      col0_q    <= outCol_q;
      last0_q   <= last;
      bypass0_q <= border || !gauss;
    end
    hs1_q     <= hSum;
    center1_q <= win_q[R][R];
    row1_q    <= row0_q;
    col1_q    <= col0_q;
    last1_q   <= last0_q;
    bypass1_q <= bypass0_q;
    sum2_q    <= vSum;
    center2_q <= center1_q;
    row2_q    <= row1_q;
    col2_q    <= col1_q;
    last2_q   <= last1_q;
    bypass2_q <= bypass1_q;
  end

endmodule

// File: tb/tb_blur_nxn.sv
// Directed bench for blur_nxn on an 8x6 image: dut3 (K=3) and dut5 (K=5) share
// clock, reset, pixel and mode; outputs are collected at negedge into queues.
`timescale 1ns/1ps
module tb_blur_nxn;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       en3, en5;
  logic [7:0] pix;
  logic [1:0] mode;
  logic       rdy3, rd3, done3, rdy5, rd5, done5;
  logic [7:0] out3, out5;
  logic [2:0] row3, col3, row5, col5;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lowCnt;

  logic [7:0] frameBuf [NPIX];
  logic [7:0] expBuf [NPIX];
  logic [7:0] q3Pix[$], q5Pix[$];
  logic [2:0] q3Row[$], q3Col[$], q5Row[$], q5Col[$];
  logic       q3Done[$], q5Done[$];
  int         q3Edge[$], acc3Edge[$];

  always #5 clk = ~clk;

  blur_nxn #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(3)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .input_pixel(pix), .mode(mode),
    .in_ready(rdy3), .rd_flag(rd3), .output_pixel(out3),
    .rows_written(row3), .cols_written(col3), .frame_done(done3));

  blur_nxn #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(5)) dut5 (
    .clk(clk), .reset(reset), .en(en5), .input_pixel(pix), .mode(mode),
    .in_ready(rdy5), .rd_flag(rd5), .output_pixel(out5),
    .rows_written(row5), .cols_written(col5), .frame_done(done5));

  always @(posedge clk) cyc <= cyc + 1;

  // At a negedge, cyc is the index of the posedge just past; an accept lands on the next one.
  always @(negedge clk) begin
    if (rd3) begin
      q3Pix.push_back(out3); q3Row.push_back(row3); q3Col.push_back(col3);
      q3Done.push_back(done3); q3Edge.push_back(cyc);
    end
    if (rd5) begin
      q5Pix.push_back(out5); q5Row.push_back(row5); q5Col.push_back(col5);
      q5Done.push_back(done5);
    end
    if (en3 && rdy3) acc3Edge.push_back(cyc + 1);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearQueues();
    q3Pix.delete(); q3Row.delete(); q3Col.delete(); q3Done.delete(); q3Edge.delete();
    q5Pix.delete(); q5Row.delete(); q5Col.delete(); q5Done.delete(); acc3Edge.delete();
  endtask

  task automatic applyStimulus(input bit useK5, input int count, input bit gaps,
                               input logic [1:0] firstMode, input logic [1:0] laterMode);
    int gap;
    for (int t = 0; t < 100 && !(useK5 ? rdy5 : rdy3); t++) tick();
    for (int n = 0; n < count; n++) begin
      if (gaps) begin
        gap = int'($urandom_range(0, 3));
        if (gap > 1) begin
          en3 = 1'b0; en5 = 1'b0;
          repeat (gap - 1) tick();
        end
      end
      mode = (n == 0) ? firstMode : laterMode;
      pix  = frameBuf[n];
      if (useK5) en5 = 1'b1; else en3 = 1'b1;
      tick();
    end
    en3 = 1'b0; en5 = 1'b0;
  endtask

  task automatic waitOutputs(input bit useK5);
    for (int t = 0; t < 300 && (useK5 ? q5Pix.size() : q3Pix.size()) < NPIX; t++) tick();
    repeat (10) tick();
  endtask

  task automatic checkFrame(input string tag, input bit useK5);
    int sz;
    logic [31:0] oPix, oRow, oCol, oDone;
    sz = useK5 ? q5Pix.size() : q3Pix.size();
    checkOutput({tag, " count"}, 32'(sz), 32'(NPIX));
    for (int n = 0; n < NPIX; n++) begin
      if (n < sz) begin
        oPix  = useK5 ? 32'(q5Pix[n])  : 32'(q3Pix[n]);
        oRow  = useK5 ? 32'(q5Row[n])  : 32'(q3Row[n]);
        oCol  = useK5 ? 32'(q5Col[n])  : 32'(q3Col[n]);
        oDone = useK5 ? 32'(q5Done[n]) : 32'(q3Done[n]);
      end else begin
        oPix = 'x; oRow = 'x; oCol = 'x; oDone = 'x;
      end
      checkOutput($sformatf("%s pix[%0d]", tag, n), oPix, 32'(expBuf[n]));
      checkOutput($sformatf("%s row[%0d]", tag, n), oRow, 32'(n / W));
      checkOutput($sformatf("%s col[%0d]", tag, n), oCol, 32'(n % W));
      checkOutput($sformatf("%s done[%0d]", tag, n), oDone, 32'(n == NPIX - 1));
    end
  endtask

  task automatic loadImpulse();
    for (int n = 0; n < NPIX; n++) begin frameBuf[n] = 8'd0; expBuf[n] = 8'd0; end
    frameBuf[2*W+2] = 8'd255;
    expBuf[1*W+1] = 8'd16; expBuf[1*W+2] = 8'd32; expBuf[1*W+3] = 8'd16;
    expBuf[2*W+1] = 8'd32; expBuf[2*W+2] = 8'd64; expBuf[2*W+3] = 8'd32;
    expBuf[3*W+1] = 8'd16; expBuf[3*W+2] = 8'd32; expBuf[3*W+3] = 8'd16;
  endtask

  task automatic loadConst(input logic [7:0] v);
    for (int n = 0; n < NPIX; n++) begin frameBuf[n] = v; expBuf[n] = v; end
  endtask

  initial begin
    reset = 1'b0; en3 = 1'b0; en5 = 1'b0; pix = 8'd0; mode = 2'b00;
    tick(); tick();
    checkOutput("reset rd_flag", 32'(rd3), 32'd0);
    checkOutput("reset frame_done", 32'(done3), 32'd0);
    checkOutput("reset output_pixel", 32'(out3), 32'd0);
    checkOutput("reset rows_written", 32'(row3), 32'd0);
    checkOutput("reset cols_written", 32'(col3), 32'd0);
    checkOutput("reset in_ready", 32'(rdy3), 32'd1);
    checkOutput("reset in_ready k5", 32'(rdy5), 32'd1);
    reset = 1'b1;
    tick();

    // Constant frame, gaussian; 0xFF is offered throughout the flush and must be ignored.
    loadConst(8'd100);
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b0, 2'b01, 2'b01);
    en3 = 1'b1; pix = 8'hFF;
    lowCnt = 0;
    for (int t = 0; t < 40 && !rdy3; t++) begin lowCnt++; tick(); end
    en3 = 1'b0;
    checkOutput("flush in_ready low cycles", 32'(lowCnt), 32'd9);
    waitOutputs(1'b0);
    checkFrame("const100", 1'b0);
    checkOutput("latency edges",
                (q3Edge.size() > 0 && acc3Edge.size() > 9) ? 32'(q3Edge[0] - acc3Edge[9]) : 'x,
                32'd3);

    loadImpulse();
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b0, 2'b01, 2'b01);
    waitOutputs(1'b0);
    checkFrame("impulse", 1'b0);

    loadConst(8'd100);
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b1, 2'b01, 2'b01);
    waitOutputs(1'b0);
    checkFrame("const100 gaps", 1'b0);

    loadImpulse();
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b1, 2'b01, 2'b01);
    waitOutputs(1'b0);
    checkFrame("impulse gaps", 1'b0);

    // Mode changes after the first pixel must not affect the frame.
    loadImpulse();
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b0, 2'b01, 2'b00);
    waitOutputs(1'b0);
    checkFrame("impulse mode held", 1'b0);

    loadImpulse();
    for (int n = 0; n < NPIX; n++) expBuf[n] = frameBuf[n];
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b0, 2'b10, 2'b10);
    waitOutputs(1'b0);
    checkFrame("impulse mode10", 1'b0);

    for (int n = 0; n < NPIX; n++) begin frameBuf[n] = 8'(n); expBuf[n] = 8'(n); end
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b0, 2'b00, 2'b00);
    waitOutputs(1'b0);
    checkFrame("ramp k3", 1'b0);

    clearQueues();
    applyStimulus(1'b1, NPIX, 1'b0, 2'b00, 2'b00);
    waitOutputs(1'b1);
    checkFrame("ramp k5", 1'b1);

    // Abort a frame after 20 pixels; the following frame must start fresh at (0,0).
    loadConst(8'd50);
    clearQueues();
    applyStimulus(1'b0, 20, 1'b0, 2'b01, 2'b01);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("midreset rd_flag", 32'(rd3), 32'd0);
    checkOutput("midreset frame_done", 32'(done3), 32'd0);
    checkOutput("midreset output_pixel", 32'(out3), 32'd0);
    checkOutput("midreset rows_written", 32'(row3), 32'd0);
    checkOutput("midreset cols_written", 32'(col3), 32'd0);
    checkOutput("midreset in_ready", 32'(rdy3), 32'd1);
    clearQueues();
    repeat (8) tick();
    checkOutput("midreset stray outputs", 32'(q3Pix.size()), 32'd0);
    clearQueues();
    applyStimulus(1'b0, NPIX, 1'b0, 2'b01, 2'b01);
    waitOutputs(1'b0);
    checkFrame("const50 after reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
